// File: rtl/simple_bus_pkg.sv
// Shared types and default widths for the simple-bus command responder.
package simple_bus_pkg;

    localparam int unsigned SB_CMD_W   = 4;
    localparam int unsigned SB_ADDR_W  = 16;
    localparam int unsigned SB_CMD_MAX = 7;

    typedef struct packed {
        logic [SB_CMD_W-1:0]  cmd;
        logic [SB_ADDR_W-1:0] addr;
    } sb_req_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } sb_rsp_state_e;

endpackage

// File: rtl/simple_bus_cmd_fifo.sv
// Synchronous FIFO of bus requests; DEPTH must be a power of two so the pointers wrap naturally.
module simple_bus_cmd_fifo
    import simple_bus_pkg::*;
#(
    parameter type         req_t = sb_req_t,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_,
    input  logic                     push,
    input  req_t                     push_data,
    input  logic                     pop,
    output req_t                     pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;

    req_t          mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [LW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full     = (count == LW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];
    assign level    = count;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/simple_bus_cmd_responder.sv
// Simple-bus target: queues cmd/saddr transfers and completes each after cfg_lat cycles with a done pulse.
module simple_bus_cmd_responder
    import simple_bus_pkg::*;
#(
    parameter int unsigned CMD_W   = SB_CMD_W,
    parameter int unsigned ADDR_W  = SB_ADDR_W,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned LAT_W   = 4,
    parameter int unsigned CMD_MAX = SB_CMD_MAX
) (
    input  logic                     clk,
    input  logic                     rst_,
    input  logic                     en,
    input  logic [CMD_W-1:0]         cmd,
    input  logic [ADDR_W-1:0]        saddr,
    output logic                     rdy,
    input  logic [LAT_W-1:0]         cfg_lat,
    output logic                     done,
    output logic [CMD_W-1:0]         done_cmd,
    output logic [ADDR_W-1:0]        done_addr,
    output logic                     err,
    output logic                     ovf,
    output logic [$clog2(DEPTH):0]   level
);

    typedef struct packed {
        logic [CMD_W-1:0]  cmd;
        logic [ADDR_W-1:0] addr;
    } req_t;

    sb_rsp_state_e    state;
    sb_rsp_state_e    state_nx;
    logic [LAT_W-1:0] cnt;
    logic [LAT_W-1:0] cnt_nx;
    req_t             head;
    req_t             act;
    req_t             fin;
    req_t             push_req;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    // rdy comes from the registered FIFO count only, never from en.
    assign rdy      = rst_ && !full;
    assign push     = en && rdy;
    assign push_req = '{cmd: cmd, addr: saddr};

    simple_bus_cmd_fifo #(
        .req_t (req_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_      (rst_),
        .push      (push),
        .push_data (push_req),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty),
        .level     (level)
    );

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        pop      = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (!empty) begin
                    pop      = 1'b1;
                    cnt_nx   = cfg_lat;
                    state_nx = (cfg_lat == '0) ? DONE : WAIT;
                end else begin
                    state_nx = IDLE;
                end
            end
            WAIT: begin
                cnt_nx = cnt - 1'b1;
                if (cnt == LAT_W'(1)) state_nx = DONE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // A zero-latency pop completes straight from the FIFO head, bypassing the active register.
    assign fin = pop ? head : act;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state     <= IDLE;
            cnt       <= '0;
            act       <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            done_cmd  <= '0;
            done_addr <= '0;
            ovf       <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (pop) act <= head;
            done <= (state_nx == DONE);
            err  <= (state_nx == DONE) && (fin.cmd > CMD_W'(CMD_MAX));
            if (state_nx == DONE) begin
                done_cmd  <= fin.cmd;
                done_addr <= fin.addr;
            end
            if (en && !rdy) ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_simple_bus_cmd_responder.sv
// Directed self-checking bench for simple_bus_cmd_responder.
module tb_simple_bus_cmd_responder;

    logic        clk = 1'b0;
    logic        rst_;
    logic        en;
    logic [3:0]  cmd;
    logic [15:0] saddr;
    logic        rdy;
    logic [3:0]  cfg_lat;
    logic        done;
    logic [3:0]  done_cmd;
    logic [15:0] done_addr;
    logic        err;
    logic        ovf;
    logic [2:0]  level;

    int unsigned checks = 0;
    int unsigned errors = 0;

    simple_bus_cmd_responder #(
        .CMD_W   (4),
        .ADDR_W  (16),
        .DEPTH   (4),
        .LAT_W   (4),
        .CMD_MAX (7)
    ) dut (
        .clk       (clk),
        .rst_      (rst_),
        .en        (en),
        .cmd       (cmd),
        .saddr     (saddr),
        .rdy       (rdy),
        .cfg_lat   (cfg_lat),
        .done      (done),
        .done_cmd  (done_cmd),
        .done_addr (done_addr),
        .err       (err),
        .ovf       (ovf),
        .level     (level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int unsigned budget, output bit got);
        got = 1'b0;
        for (int unsigned k = 0; k < budget && !got; k++) begin
            tick();
            if (done) got = 1'b1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          got;
        int unsigned n;

        rst_ = 1'b0; en = 1'b0; cmd = '0; saddr = '0; cfg_lat = '0;
        #1;
        chk("rst_rdy",   rdy,   0);
        chk("rst_done",  done,  0);
        chk("rst_level", level, 0);
        chk("rst_ovf",   ovf,   0);
        tick(); tick();
        rst_ = 1'b1;

        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_rdy",   rdy,   1);
            chk("idle_level", level, 0);
            chk("idle_done",  done,  0);
            chk("idle_ovf",   ovf,   0);
        end

        // single transfer, latency 3: done after accept edge + 4
        cfg_lat = 4'd3;
        en = 1'b1; cmd = 4'd2; saddr = 16'h1234;
        tick();
        en = 1'b0;
        chk("lat3_level_after_push", level, 1);
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("lat3_done", done, (k == 4) ? 1 : 0);
        end
        chk("lat3_cmd",  done_cmd,  2);
        chk("lat3_addr", done_addr, 16'h1234);
        chk("lat3_err",  err,       0);
        tick();
        chk("lat3_done_clear", done,     0);
        chk("lat3_cmd_hold",   done_cmd, 2);

        // zero latency, 4 back-to-back: consecutive dones in order
        cfg_lat = 4'd0;
        for (int i = 0; i < 4; i++) begin
            en = 1'b1; cmd = 4'(i); saddr = 16'h0100 + 16'(i);
            tick();
            chk("lat0_level", level, 1);
            chk("lat0_done",  done, (i > 0) ? 1 : 0);
            if (i > 0) chk("lat0_addr", done_addr, 16'h0100 + 16'(i - 1));
        end
        en = 1'b0;
        tick();
        chk("lat0_done_last",  done,      1);
        chk("lat0_cmd_last",   done_cmd,  3);
        chk("lat0_addr_last",  done_addr, 16'h0103);
        chk("lat0_level_last", level,     0);
        tick();
        chk("lat0_done_end", done, 0);

        // latency 5, 6 back-to-back: FIFO fills, 6th dropped, ovf sticky
        cfg_lat = 4'd5;
        for (int i = 0; i < 6; i++) begin
            chk("ovf_rdy_before", rdy, (i < 5) ? 1 : 0);
            en = 1'b1; cmd = 4'd1; saddr = 16'h0200 + 16'(i);
            tick();
        end
        en = 1'b0;
        chk("ovf_set",   ovf,   1);
        chk("ovf_level", level, 4);
        n = 0;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (done) begin
                chk("ovf_addr_order", done_addr, 16'h0200 + 16'(n));
                n++;
            end
        end
        chk("ovf_done_count", n,     5);
        chk("ovf_sticky",     ovf,   1);
        chk("ovf_level_end",  level, 0);

        // illegal command flags err, next legal one does not
        cfg_lat = 4'd1;
        en = 1'b1; cmd = 4'hF; saddr = 16'hABCD;
        tick();
        cmd = 4'd7; saddr = 16'h0007;
        tick();
        en = 1'b0;
        wait_done(10, got);
        chk("ill_done_seen", got,       1);
        chk("ill_err",       err,       1);
        chk("ill_cmd",       done_cmd,  4'hF);
        chk("ill_addr",      done_addr, 16'hABCD);
        wait_done(10, got);
        chk("leg_done_seen", got,      1);
        chk("leg_err",       err,      0);
        chk("leg_cmd",       done_cmd, 7);
        tick(); tick();

        // reset during WAIT with 3 queued
        cfg_lat = 4'd7;
        for (int i = 0; i < 4; i++) begin
            en = 1'b1; cmd = 4'd3; saddr = 16'h0300 + 16'(i);
            tick();
        end
        en = 1'b0;
        chk("mid_level_before", level, 3);
        #2;
        rst_ = 1'b0;
        #1;
        chk("mid_rst_done",  done,  0);
        chk("mid_rst_level", level, 0);
        chk("mid_rst_rdy",   rdy,   0);
        chk("mid_rst_ovf",   ovf,   0);
        tick(); tick();
        rst_ = 1'b1;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done) n++;
        end
        chk("post_rst_no_done", n,     0);
        chk("post_rst_level",   level, 0);
        chk("post_rst_rdy",     rdy,   1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
